// File: rtl/obi_imem_responder.sv
// OBI responder in front of a synchronous single-port SRAM with an in-order response FIFO.
// Optional OBI_RESP_ERR_EN: out-of-range requests answer with obi_err_o=1 and skip the SRAM.
module obi_imem_responder #(
    parameter int unsigned MEM_AW    = 14,
    parameter int unsigned DEPTH     = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk_i,
    input  logic              rst_n_i,

    input  logic              obi_req_i,
    output logic              obi_gnt_o,
    input  logic [31:0]       obi_addr_i,
    input  logic              obi_we_i,
    input  logic [3:0]        obi_be_i,
    input  logic [31:0]       obi_wdata_i,
    output logic              obi_rvalid_o,
    input  logic              obi_rready_i,
    output logic [31:0]       obi_rdata_o,
`ifdef OBI_RESP_ERR_EN
    output logic              obi_err_o,
`endif

    output logic              sram_req_o,
    output logic              sram_we_o,
    output logic [MEM_AW-1:0] sram_addr_o,
    output logic [3:0]        sram_be_o,
    output logic [31:0]       sram_wdata_o,
    input  logic [31:0]       sram_rdata_i
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH) + 1;
    localparam logic [CntW:0] DepthC = DEPTH[CntW:0];

    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [CntW-1:0] cnt_t;

    logic        pending_q;
    logic        pend_we_q;
    logic        pend_err_q;
    ptr_t        wptr_q;
    ptr_t        rptr_q;
    cnt_t        count_q;
    logic [31:0] fifo_data_q [DEPTH];

    logic [31:0] offset;
    logic        in_range;
    logic [CntW:0] occ;
    logic        gnt;
    logic        empty;
    logic        full;
    logic        push;
    logic        pop;
    logic        rvalid;
    logic [31:0] resp_data;

    function automatic ptr_t ptr_inc(ptr_t p);
        if (p == ptr_t'(DEPTH - 1)) begin
            return '0;
        end
        return p + ptr_t'(1);
    endfunction

    // Bits above the memory window and the byte offset play no part in the SRAM address.
    assign offset = obi_addr_i - BASE_ADDR;

    logic unused_offset;
    assign unused_offset = ^{offset[31:MEM_AW+2], offset[1:0]};

`ifdef OBI_RESP_ERR_EN
    assign in_range = ((offset >> (MEM_AW + 2)) == 32'd0);
`else
    assign in_range = 1'b1;
`endif

    assign occ   = {1'b0, count_q} + {{CntW{1'b0}}, pending_q};
    assign empty = (count_q == '0);
    assign full  = (count_q == DepthC[CntW-1:0]);

    // Gated by reset so no grant can escape while the responder is held in reset.
    assign gnt       = rst_n_i & obi_req_i & (occ < DepthC);
    assign obi_gnt_o = gnt;

    assign sram_req_o   = gnt & in_range;
    assign sram_we_o    = sram_req_o & obi_we_i;
    assign sram_addr_o  = offset[MEM_AW+1:2];
    assign sram_be_o    = obi_be_i;
    assign sram_wdata_o = obi_wdata_i;

    assign resp_data = (pend_we_q || pend_err_q) ? 32'd0 : sram_rdata_i;

    assign rvalid = pending_q | ~empty;
    assign pop    = ~empty & obi_rready_i;
    // A fresh response bypasses the FIFO only when the FIFO is empty and it is taken at once.
    assign push   = pending_q & ~(empty & obi_rready_i);

    always_comb begin
        obi_rvalid_o = rvalid;
        obi_rdata_o  = 32'd0;
        if (!empty) begin
            obi_rdata_o = fifo_data_q[rptr_q];
        end else if (pending_q) begin
            obi_rdata_o = resp_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pending_q  <= 1'b0;
            pend_we_q  <= 1'b0;
            pend_err_q <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
        end else begin
            pending_q <= gnt;
            if (gnt) begin
                pend_we_q  <= obi_we_i;
                pend_err_q <= ~in_range;
            end
            if (push) begin
                wptr_q <= ptr_inc(wptr_q);
            end
            if (pop) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + cnt_t'(1);
                2'b01:   count_q <= count_q - cnt_t'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_data_q[wptr_q] <= resp_data;
        end
    end

`ifdef OBI_RESP_ERR_EN
    logic fifo_err_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_err_q[wptr_q] <= pend_err_q;
        end
    end

    always_comb begin
        obi_err_o = 1'b0;
        if (!empty) begin
            obi_err_o = fifo_err_q[rptr_q];
        end else if (pending_q) begin
            obi_err_o = pend_err_q;
        end
    end
`endif

    // The grant rule keeps occupancy within DEPTH, so a push into a full FIFO is a design bug.
    assert property (@(posedge clk_i) disable iff (!rst_n_i) !(push && full && !pop));

endmodule

// File: tb/tb_obi_imem_responder.sv
// Directed plus randomized bench for obi_imem_responder against a transaction-level model.
// Works with or without OBI_RESP_ERR_EN defined.
module tb_obi_imem_responder;

    localparam int unsigned MemAw = 4;
    localparam int unsigned Depth = 2;
    localparam int unsigned Words = 16;
    localparam logic [31:0] Base  = 32'h0000_0000;

    logic             clk_i;
    logic             rst_n_i;
    logic             obi_req_i;
    logic             obi_gnt_o;
    logic [31:0]      obi_addr_i;
    logic             obi_we_i;
    logic [3:0]       obi_be_i;
    logic [31:0]      obi_wdata_i;
    logic             obi_rvalid_o;
    logic             obi_rready_i;
    logic [31:0]      obi_rdata_o;
    logic             sram_req_o;
    logic             sram_we_o;
    logic [MemAw-1:0] sram_addr_o;
    logic [3:0]       sram_be_o;
    logic [31:0]      sram_wdata_o;
    logic [31:0]      sram_rdata_i;
`ifdef OBI_RESP_ERR_EN
    logic             obi_err_o;
`endif

    obi_imem_responder #(
        .MEM_AW    (MemAw),
        .DEPTH     (Depth),
        .BASE_ADDR (Base)
    ) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .obi_req_i    (obi_req_i),
        .obi_gnt_o    (obi_gnt_o),
        .obi_addr_i   (obi_addr_i),
        .obi_we_i     (obi_we_i),
        .obi_be_i     (obi_be_i),
        .obi_wdata_i  (obi_wdata_i),
        .obi_rvalid_o (obi_rvalid_o),
        .obi_rready_i (obi_rready_i),
        .obi_rdata_o  (obi_rdata_o),
`ifdef OBI_RESP_ERR_EN
        .obi_err_o    (obi_err_o),
`endif
        .sram_req_o   (sram_req_o),
        .sram_we_o    (sram_we_o),
        .sram_addr_o  (sram_addr_o),
        .sram_be_o    (sram_be_o),
        .sram_wdata_o (sram_wdata_o),
        .sram_rdata_i (sram_rdata_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } resp_t;

    resp_t       exp_q[$];
    logic [31:0] ref_mem [Words];
    int          n_cmp = 0;
    int          n_err = 0;

    function automatic logic [31:0] init_word(int i);
        if (i == 5) return 32'hDEAD_BEEF;
        if (i == 8) return 32'hFFFF_FFFF;
        return 32'h9E37_79B9 * 32'(i + 1);
    endfunction

    // Synchronous SRAM: read data appears the cycle after the strobe.
    logic [31:0] sram [Words];
    bit          loaded = 1'b0;
    always @(posedge clk_i) begin
        if (!loaded) begin
            for (int i = 0; i < int'(Words); i++) sram[i] <= init_word(i);
            loaded <= 1'b1;
        end else if (sram_req_o) begin
            if (sram_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (sram_be_o[b]) sram[sram_addr_o][8*b +: 8] <= sram_wdata_o[8*b +: 8];
            end else begin
                sram_rdata_i <= sram[sram_addr_o];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic in_rng(logic [31:0] a);
`ifdef OBI_RESP_ERR_EN
        return (a - Base) < 32'(Words * 4);
`else
        return 1'b1;
`endif
    endfunction

    function automatic int widx(logic [31:0] a);
        return int'(((a - Base) / 4) % Words);
    endfunction

    // One clock: drive at negedge, check combinational outputs, then advance the model at posedge.
    task automatic cyc(input logic req, input logic [31:0] addr, input logic we,
                       input logic [3:0] be, input logic [31:0] wd, input logic rr);
        logic  exp_gnt;
        logic  exp_sreq;
        logic  had_resp;
        resp_t r;
        int    idx;
        @(negedge clk_i);
        obi_req_i    = req;
        obi_addr_i   = addr;
        obi_we_i     = we;
        obi_be_i     = be;
        obi_wdata_i  = wd;
        obi_rready_i = rr;
        #1;
        exp_gnt  = req && (exp_q.size() < int'(Depth));
        exp_sreq = exp_gnt && in_rng(addr);
        had_resp = (exp_q.size() > 0);
        idx      = widx(addr);
        check("gnt", 32'(obi_gnt_o), 32'(exp_gnt));
        check("sram_req", 32'(sram_req_o), 32'(exp_sreq));
        if (exp_sreq) begin
            check("sram_we", 32'(sram_we_o), 32'(we));
            check("sram_addr", 32'(sram_addr_o), 32'(idx));
            check("sram_be", 32'(sram_be_o), 32'(be));
            check("sram_wdata", sram_wdata_o, wd);
        end
        check("rvalid", 32'(obi_rvalid_o), 32'(had_resp));
        if (had_resp) begin
            check("rdata", obi_rdata_o, exp_q[0].data);
`ifdef OBI_RESP_ERR_EN
            check("err", 32'(obi_err_o), 32'(exp_q[0].err));
`endif
        end else begin
            check("rdata_idle", obi_rdata_o, 32'd0);
        end
        @(posedge clk_i);
        if (had_resp && rr) void'(exp_q.pop_front());
        if (exp_gnt) begin
            r.err  = !in_rng(addr);
            r.data = (we || r.err) ? 32'd0 : ref_mem[idx];
            if (we && !r.err)
                for (int b = 0; b < 4; b++)
                    if (be[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
            exp_q.push_back(r);
        end
    endtask

    task automatic rd(input logic [31:0] addr, input logic rr);
        cyc(1'b1, addr, 1'b0, 4'hF, 32'd0, rr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'd0, 1'b0, 4'h0, 32'd0, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < int'(Words); i++) ref_mem[i] = init_word(i);
        rst_n_i      = 1'b0;
        obi_req_i    = 1'b0;
        obi_addr_i   = 32'd0;
        obi_we_i     = 1'b0;
        obi_be_i     = 4'h0;
        obi_wdata_i  = 32'd0;
        obi_rready_i = 1'b0;

        #2;
        check("rst_gnt", 32'(obi_gnt_o), 32'd0);
        check("rst_rvalid", 32'(obi_rvalid_o), 32'd0);
        check("rst_rdata", obi_rdata_o, 32'd0);
        check("rst_sram_req", 32'(sram_req_o), 32'd0);
        check("rst_sram_we", 32'(sram_we_o), 32'd0);
        obi_req_i = 1'b1;
        obi_we_i  = 1'b1;
        #1;
        check("rst_gnt_req", 32'(obi_gnt_o), 32'd0);
        check("rst_sram_req_req", 32'(sram_req_o), 32'd0);
        obi_req_i = 1'b0;
        obi_we_i  = 1'b0;
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // Single read of word 5.
        rd(32'h14, 1'b1);
        idle(2);

        // Back-to-back reads, no backpressure.
        rd(32'h0, 1'b1);
        rd(32'h4, 1'b1);
        rd(32'h8, 1'b1);
        idle(2);

        // Backpressure fills the FIFO, third request waits for the first pop.
        rd(32'h0, 1'b0);
        rd(32'h4, 1'b0);
        rd(32'h8, 1'b0);
        rd(32'h8, 1'b0);
        rd(32'h8, 1'b1);
        rd(32'h8, 1'b1);
        idle(3);

        // Partial write, then read back.
        cyc(1'b1, 32'h20, 1'b1, 4'b0011, 32'h1234_5678, 1'b1);
        rd(32'h20, 1'b1);
        idle(2);

        // Reset with two responses queued.
        rd(32'h0, 1'b0);
        rd(32'h4, 1'b0);
        @(negedge clk_i);
        obi_req_i    = 1'b1;
        obi_addr_i   = 32'h8;
        obi_we_i     = 1'b0;
        obi_rready_i = 1'b0;
        #1;
        rst_n_i = 1'b0;
        #1;
        check("midrst_gnt", 32'(obi_gnt_o), 32'd0);
        check("midrst_rvalid", 32'(obi_rvalid_o), 32'd0);
        check("midrst_rdata", obi_rdata_o, 32'd0);
        check("midrst_sram_req", 32'(sram_req_o), 32'd0);
        exp_q.delete();
        obi_req_i = 1'b0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        rd(32'h14, 1'b1);
        idle(2);

        // Beyond the memory window: aliases by default, error response when enabled.
        rd(32'h40, 1'b1);
        rd(32'h14, 1'b1);
        cyc(1'b1, 32'h44, 1'b1, 4'hF, 32'hCAFE_F00D, 1'b1);
        rd(32'h4, 1'b1);
        idle(2);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = ($urandom % 4 == 0) ? $urandom : 32'($urandom_range(0, 63));
            cyc(($urandom % 4) != 0, a, ($urandom % 4) == 0, 4'($urandom),
                $urandom, ($urandom % 3) != 0);
        end
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
